// File: rtl/seq_fsm_6s2i2o_mo_stim.sv
// Shortest-path stimulus generator and Moore-output checker for the six-state FSM.
// Define SEQ_FSM_STIM_CHECK_EN to compare obs_out_i against the shadow Moore output.
module seq_fsm_6s2i2o_mo_stim (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_val_i,
  output logic       req_rdy_o,
  input  logic [2:0] req_target_i,
  output logic       resp_val_o,
  input  logic       resp_rdy_i,
  output logic [2:0] resp_steps_o,
  output logic       resp_bad_o,
  output logic [1:0] drv_in_o,
  input  logic [1:0] obs_out_i,
  output logic       chk_err_o
);

  typedef enum logic [2:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5
  } fsm_st_e;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_RUN  = 2'd1,
    CTL_RESP = 2'd2
  } ctl_st_e;

  function automatic fsm_st_e fsm_next(input fsm_st_e s, input logic [1:0] in_v);
    fsm_st_e n;
    n = ST_A;
    case (s)
      ST_A: begin
        case (in_v)
          2'b01:   n = ST_B;
          2'b11:   n = ST_E;
          default: n = ST_A;
        endcase
      end
      ST_B, ST_D: begin
        case (in_v)
          2'b00:   n = ST_C;
          2'b01:   n = ST_B;
          2'b11:   n = ST_E;
          default: n = ST_A;
        endcase
      end
      ST_C: begin
        case (in_v)
          2'b01:   n = ST_D;
          2'b11:   n = ST_E;
          default: n = ST_A;
        endcase
      end
      ST_E: begin
        case (in_v)
          2'b00, 2'b01: n = ST_F;
          2'b11:        n = ST_E;
          default:      n = ST_A;
        endcase
      end
      default: n = ST_A;
    endcase
    return n;
  endfunction

  // Lowest input code that moves one hop closer along a shortest path.
  function automatic logic [1:0] next_hop(input fsm_st_e s, input logic [2:0] t);
    logic [1:0] c;
    c = 2'b00;
    case (t)
      3'd0: begin
        case (s)
          ST_C, ST_F: c = 2'b00;
          default:    c = 2'b10;
        endcase
      end
      3'd1: begin
        case (s)
          ST_A, ST_D: c = 2'b01;
          ST_E:       c = 2'b10;
          default:    c = 2'b00;
        endcase
      end
      3'd2: begin
        case (s)
          ST_A:    c = 2'b01;
          ST_E:    c = 2'b10;
          default: c = 2'b00;
        endcase
      end
      3'd3: begin
        case (s)
          ST_A, ST_C: c = 2'b01;
          ST_E:       c = 2'b10;
          default:    c = 2'b00;
        endcase
      end
      3'd4: begin
        case (s)
          ST_F:    c = 2'b00;
          default: c = 2'b11;
        endcase
      end
      3'd5: begin
        case (s)
          ST_E:    c = 2'b00;
          default: c = 2'b11;
        endcase
      end
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Idle inputs hold A, B and E in place; C, D and F fall back to A.
  function automatic logic [1:0] idle_in(input fsm_st_e s);
    logic [1:0] c;
    case (s)
      ST_A:    c = 2'b00;
      ST_B:    c = 2'b01;
      ST_E:    c = 2'b11;
      default: c = 2'b10;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] moore_out(input fsm_st_e s);
    logic [1:0] o;
    case (s)
      ST_D:       o = 2'b01;
      ST_E, ST_F: o = 2'b10;
      default:    o = 2'b00;
    endcase
    return o;
  endfunction

  ctl_st_e    ctl_q;
  fsm_st_e    shadow_q;
  logic [2:0] target_q;
  logic [2:0] steps_q;
  logic       req_rdy_q;
  logic       resp_val_q;
  logic [2:0] resp_steps_q;
  logic       resp_bad_q;
  logic       at_target_s;
  logic [1:0] drv_s;

  assign at_target_s = (shadow_q == fsm_st_e'(target_q));

  // Path input is a pure function of registered state; reset forces the neutral code.
  always_comb begin
    drv_s = 2'b00;
    if (reset_i) begin
      drv_s = 2'b00;
    end else if ((ctl_q == CTL_RUN) && !at_target_s) begin
      drv_s = next_hop(shadow_q, target_q);
    end else begin
      drv_s = idle_in(shadow_q);
    end
  end

  // Control FSM, shadow tracking and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctl_q        <= CTL_IDLE;
      shadow_q     <= ST_A;
      target_q     <= 3'd0;
      steps_q      <= 3'd0;
      req_rdy_q    <= 1'b0;
      resp_val_q   <= 1'b0;
      resp_steps_q <= 3'd0;
      resp_bad_q   <= 1'b0;
    end else begin
      shadow_q <= fsm_next(shadow_q, drv_s);
      case (ctl_q)
        CTL_IDLE: begin
          if (req_val_i && req_rdy_q) begin
            target_q  <= req_target_i;
            steps_q   <= 3'd0;
            req_rdy_q <= 1'b0;
            if (req_target_i > 3'd5) begin
              ctl_q        <= CTL_RESP;
              resp_val_q   <= 1'b1;
              resp_bad_q   <= 1'b1;
              resp_steps_q <= 3'd0;
            end else begin
              ctl_q <= CTL_RUN;
            end
          end else begin
            req_rdy_q <= 1'b1;
          end
        end
        CTL_RUN: begin
          if (at_target_s) begin
            ctl_q        <= CTL_RESP;
            resp_val_q   <= 1'b1;
            resp_bad_q   <= 1'b0;
            resp_steps_q <= steps_q;
          end else begin
            steps_q <= steps_q + 3'd1;
          end
        end
        CTL_RESP: begin
          if (resp_rdy_i) begin
            ctl_q      <= CTL_IDLE;
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
          end else begin
            ctl_q <= CTL_RESP;
          end
        end
        default: begin
          ctl_q      <= CTL_IDLE;
          req_rdy_q  <= 1'b0;
          resp_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy_o    = req_rdy_q;
  assign resp_val_o   = resp_val_q;
  assign resp_steps_o = resp_steps_q;
  assign resp_bad_o   = resp_bad_q;
  assign drv_in_o     = drv_s;

`ifdef SEQ_FSM_STIM_CHECK_EN
  logic chk_err_q;

  // Sticky mismatch between the observed and predicted Moore output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chk_err_q <= 1'b0;
    end else if (obs_out_i != moore_out(shadow_q)) begin
      chk_err_q <= 1'b1;
    end else begin
      chk_err_q <= chk_err_q;
    end
  end

  assign chk_err_o = chk_err_q;
`else
  logic [1:0] unused_obs_s;
  assign unused_obs_s = obs_out_i;
  assign chk_err_o    = 1'b0;
`endif

endmodule
